// File: rtl/gfx_pkg.sv
// Shared tile-map geometry, write-queue entry layout and arbiter state encoding.
package gfx_pkg;
    localparam int TILE_COLS = 16;
    localparam int TILE_ROWS = 16;
    localparam int COORD_W   = $clog2(TILE_COLS);
    localparam int ADDR_W    = $clog2(TILE_COLS * TILE_ROWS);
    localparam int ID_W      = 9;

    // Queued CPU write: addr is {sprite_y, sprite_x}
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } wr_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;
endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO; pushes when full and pops when empty are ignored.
module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[PW-1:0]];

    // Next storage contents and pointers
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[PW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/tile_ram_arbiter.sv
// Single-port tile-map RAM arbiter: VGA lookups first, then clear sweep, then queued CPU writes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no sweep; free RAM cycles drain the CPU write queue
// ST_CLEAR | sweeping clr_ptr 0..255 writing 0 in every cycle VGA leaves free
module tile_ram_arbiter
    import gfx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        fclk,
    input  logic                        rst,
    input  logic                        wrn,
    input  logic [COORD_W-1:0]          sprite_x,
    input  logic [COORD_W-1:0]          sprite_y,
    input  logic [ID_W-1:0]             sprite_id,
    input  logic                        clr_req,
    input  logic                        vga_req,
    input  logic [ADDR_W-1:0]           vga_addr,
    output logic                        vga_valid,
    output logic [ID_W-1:0]             vga_tile,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_we,
    output logic [ID_W-1:0]             ram_wdata,
    input  logic [ID_W-1:0]             ram_rdata,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    logic                         s1_q, s2_q, s3_q;
    logic                         wr_push;
    wr_entry_t                    push_entry;
    wr_entry_t                    head_entry;
    logic [$bits(wr_entry_t)-1:0] head_bits;
    logic                         fifo_pop, fifo_full, fifo_empty;
    arb_state_t                   state_q, state_d;
    logic [ADDR_W-1:0]            clr_ptr_q, clr_ptr_d;
    logic                         clr_done_q, clr_done_d;
    logic                         clr_wr;
    logic                         overflow_q, overflow_d;
    logic [ADDR_W-1:0]            ram_addr_q, ram_addr_d;
    logic                         vga_p1_q;
    logic                         vga_valid_q;
    logic [ID_W-1:0]              vga_tile_q, vga_tile_d;

    // Bring wrn into fclk and keep one extra stage to spot its falling edge
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= wrn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign wr_push    = s3_q && !s2_q;
    assign push_entry = '{addr: {sprite_y, sprite_x}, id: sprite_id};
    assign head_entry = wr_entry_t'(head_bits);

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_wr_fifo (
        .clk   (fclk),
        .rst_n (rst),
        .push  (wr_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Per-cycle RAM grant; an idle cycle keeps the previous address on the bus
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ram_addr_q;
        ram_wdata = '0;
        fifo_pop  = 1'b0;
        clr_wr    = 1'b0;
        if (vga_req) begin
            ram_addr = vga_addr;
        end else if (state_q == ST_CLEAR) begin
            ram_addr = clr_ptr_q;
            ram_we   = 1'b1;
            clr_wr   = 1'b1;
        end else if (!fifo_empty) begin
            ram_addr  = head_entry.addr;
            ram_wdata = head_entry.id;
            ram_we    = 1'b1;
            fifo_pop  = 1'b1;
        end
        ram_addr_d = ram_addr;
        overflow_d = overflow_q || (wr_push && fifo_full);
        vga_tile_d = vga_p1_q ? ram_rdata : vga_tile_q;
    end

    // Clear-sweep next state; a clr_req during a sweep is ignored
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_wr) begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (&clr_ptr_q) begin
                        state_d    = ST_IDLE;
                        clr_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear-sweep state register
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            clr_ptr_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Address hold, sticky overflow and the two-stage VGA return pipeline
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            ram_addr_q  <= '0;
            overflow_q  <= 1'b0;
            vga_p1_q    <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_tile_q  <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            overflow_q  <= overflow_d;
            vga_p1_q    <= vga_req;
            vga_valid_q <= vga_p1_q;
            vga_tile_q  <= vga_tile_d;
        end
    end

    assign vga_valid = vga_valid_q;
    assign vga_tile  = vga_tile_q;
    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_done  = clr_done_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Scoreboard bench for tile_ram_arbiter: expected RAM writes and VGA returns are queued at issue
// time and a negedge monitor retires them against what the DUT presents.
module tb_tile_ram_arbiter;
    import gfx_pkg::*;

    typedef struct {
        logic [7:0] addr;
        logic [8:0] id;
    } wr_t;

    typedef struct {
        int         due;
        logic [8:0] tile;
    } vga_t;

    logic       fclk = 1'b0;
    logic       rst = 1'b0;
    logic       wrn = 1'b1;
    logic [3:0] sprite_x = '0;
    logic [3:0] sprite_y = '0;
    logic [8:0] sprite_id = '0;
    logic       clr_req = 1'b0;
    logic       vga_req = 1'b0;
    logic [7:0] vga_addr = '0;
    logic       vga_valid;
    logic [8:0] vga_tile;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [8:0] ram_wdata;
    logic [8:0] ram_rdata = '0;
    logic       clr_busy;
    logic       clr_done;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vga_mode = 0;
    logic [7:0] vga_fix_addr = '0;
    logic [8:0] vga_fix_tile = '0;
    logic [8:0] last_tile = '0;

    wr_t  wr_exp[$];
    vga_t vga_exp[$];
    logic [8:0] mem [256];
    logic [8:0] shadow [256];

    tile_ram_arbiter #(.FIFO_DEPTH(4)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .wrn        (wrn),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .sprite_id  (sprite_id),
        .clr_req    (clr_req),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_valid  (vga_valid),
        .vga_tile   (vga_tile),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 fclk = ~fclk;

    always @(posedge fclk) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-before-write
    always @(posedge fclk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: retire expected RAM writes and VGA returns as the DUT presents them
    initial begin
        wr_t  e;
        vga_t v;
        forever begin
            @(negedge fclk);
            if (rst) begin
                if (ram_we) begin
                    if (wr_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                                 ram_addr, ram_wdata, cyc);
                    end else begin
                        e = wr_exp.pop_front();
                        chk("ram_addr", 64'(ram_addr), 64'(e.addr));
                        chk("ram_wdata", 64'(ram_wdata), 64'(e.id));
                        shadow[e.addr] = e.id;
                    end
                end
                if (vga_exp.size() > 0 && vga_exp[0].due == cyc) begin
                    v = vga_exp.pop_front();
                    chk("vga_valid_due", 64'(vga_valid), 64'd1);
                    chk("vga_tile", 64'(vga_tile), 64'(v.tile));
                    last_tile = v.tile;
                end else begin
                    chk("vga_valid_idle", 64'(vga_valid), 64'd0);
                    chk("vga_tile_hold", 64'(vga_tile), 64'(last_tile));
                end
            end
        end
    end

    // Advance one cycle and drive this cycle's VGA request
    task automatic tick();
        vga_t v;
        @(posedge fclk);
        #1;
        if (vga_mode == 1 || (vga_mode == 2 && $urandom_range(1, 0) == 1)) begin
            vga_req  = 1'b1;
            vga_addr = 8'($urandom_range(255, 0));
            v.due    = cyc + 2;
            v.tile   = shadow[vga_addr];
            vga_exp.push_back(v);
        end else if (vga_mode == 3) begin
            vga_req  = 1'b1;
            vga_addr = vga_fix_addr;
            v.due    = cyc + 2;
            v.tile   = vga_fix_tile;
            vga_exp.push_back(v);
        end else begin
            vga_req = 1'b0;
        end
    endtask

    task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [8:0] id,
                            input int low, input bit accepted);
        wr_t e;
        sprite_x  = x;
        sprite_y  = y;
        sprite_id = id;
        wrn       = 1'b0;
        if (accepted) begin
            e.addr = {y, x};
            e.id   = id;
            wr_exp.push_back(e);
        end
        repeat (low) tick();
        wrn = 1'b1;
        repeat (3) tick();
    endtask

    task automatic rnd_write(input bit accepted);
        do_write(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 9'($urandom_range(511, 0)), 4, accepted);
    endtask

    task automatic queue_clear();
        wr_t e;
        for (int i = 0; i < 256; i++) begin
            e.addr = 8'(i);
            e.id   = '0;
            wr_exp.push_back(e);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic wait_clear_at(input logic [7:0] a);
        int n;
        n = 0;
        do begin
            @(negedge fclk);
            n++;
        end while (!(ram_we && clr_busy && ram_addr == a) && n < 400);
        chk("wait_clear_addr", 64'(ram_we && ram_addr == a), 64'd1);
    endtask

    // Watchdog
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, busy, done, wes, n;
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        // Reset state
        #23;
        chk("rst_outputs", {vga_valid, vga_tile, ram_addr, ram_we, ram_wdata, clr_busy, clr_done, fifo_count, overflow}, 64'd0);
        @(posedge fclk);
        #1 rst = 1'b1;
        repeat (2) tick();

        // Single write: pop visible in the 4th cycle counting the fall cycle
        begin
            wr_t e;
            e.addr = 8'h23;
            e.id   = 9'h1A5;
            wr_exp.push_back(e);
        end
        sprite_x  = 4'd3;
        sprite_y  = 4'd2;
        sprite_id = 9'h1A5;
        wrn       = 1'b0;
        c0        = cyc;
        @(negedge fclk); chk("t1_we_c0", 64'(ram_we), 64'd0);
        tick(); @(negedge fclk); chk("t1_we_c1", 64'(ram_we), 64'd0);
        tick(); @(negedge fclk); chk("t1_we_c2", 64'(ram_we), 64'd0);
        chk("t1_count_c2", 64'(fifo_count), 64'd0);
        tick(); @(negedge fclk); chk("t1_we_c3", 64'(ram_we), 64'd1);
        chk("t1_count_c3", 64'(fifo_count), 64'd1);
        chk("t1_cycle", 64'(cyc - c0), 64'd3);
        tick(); @(negedge fclk); chk("t1_we_c4", 64'(ram_we), 64'd0);
        chk("t1_count_c4", 64'(fifo_count), 64'd0);
        tick();
        wrn = 1'b1;
        repeat (3) tick();

        // VGA lookup of the tile just written
        vga_fix_addr = 8'h23;
        vga_fix_tile = 9'h1A5;
        vga_mode = 3;
        tick();
        vga_mode = 0;
        repeat (4) tick();

        // Full clear with no VGA traffic
        queue_clear();
        busy = 0; done = 0; wes = 0;
        repeat (300) begin
            @(negedge fclk);
            if (clr_busy) busy++;
            if (clr_done) done++;
            if (clr_busy && ram_we) wes++;
        end
        chk("clr_busy_cycles", 64'(busy), 64'd256);
        chk("clr_we_cycles", 64'(wes), 64'd256);
        chk("clr_done_pulses", 64'(done), 64'd1);
        chk("clr_queue_drained", 64'(wr_exp.size()), 64'd0);

        // Second clr_req mid-sweep is ignored; a write queued then lands after the sweep
        queue_clear();
        wait_clear_at(8'd100);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        rnd_write(1'b1);
        repeat (300) @(negedge fclk);
        chk("clr2_queue_drained", 64'(wr_exp.size()), 64'd0);
        chk("clr2_busy_after", 64'(clr_busy), 64'd0);

        // VGA saturating the port stalls three queued writes
        vga_mode = 1;
        repeat (3) rnd_write(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge fclk);
            chk("stall_we", 64'(ram_we), 64'd0);
        end
        chk("stall_count", 64'(fifo_count), 64'd3);
        vga_mode = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge fclk);
            chk("drain_we", 64'(ram_we), 64'd1);
        end
        tick();
        @(negedge fclk);
        chk("drain_count", 64'(fifo_count), 64'd0);

        // Overflow: six writes into a depth-4 queue while stalled
        vga_mode = 1;
        repeat (4) rnd_write(1'b1);
        chk("ovf_count_full", 64'(fifo_count), 64'd4);
        chk("ovf_before", 64'(overflow), 64'd0);
        repeat (2) rnd_write(1'b0);
        chk("ovf_count_sat", 64'(fifo_count), 64'd4);
        chk("ovf_after", 64'(overflow), 64'd1);
        vga_mode = 0;
        repeat (8) tick();
        chk("ovf_drained", 64'(fifo_count), 64'd0);
        chk("ovf_queue_empty", 64'(wr_exp.size()), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Random writes interleaved with random VGA lookups
        vga_mode = 2;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            while (wr_exp.size() >= 3 && n < 200) begin
                tick();
                n++;
            end
            chk("rnd_backlog", 64'(wr_exp.size() < 3), 64'd1);
            do_write(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                     9'($urandom_range(511, 0)), $urandom_range(6, 4), 1'b1);
        end
        vga_mode = 0;
        repeat (20) tick();
        chk("rnd_queue_empty", 64'(wr_exp.size()), 64'd0);
        chk("rnd_vga_empty", 64'(vga_exp.size()), 64'd0);

        // Reset in the middle of a sweep
        queue_clear();
        wait_clear_at(8'd50);
        #2 rst = 1'b0;
        #1;
        chk("midclr_rst_outputs", {vga_valid, vga_tile, ram_addr, ram_we, ram_wdata, clr_busy, clr_done, fifo_count, overflow}, 64'd0);
        wr_exp.delete();
        vga_exp.delete();
        last_tile = '0;
        repeat (2) @(posedge fclk);
        #1 rst = 1'b1;
        repeat (300) tick();
        chk("midclr_busy_after", 64'(clr_busy), 64'd0);
        chk("midclr_overflow", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
